// File: rtl/led_status_ctrl.sv
// Status LED driver: blink prescaler, fault-acknowledge FSM, lamp test.
// Define LED_SIM_FAST_BLINK_EN to force an 8-cycle blink half-period.
module led_status_ctrl #(
   parameter int NUM_LEDS   = 3,
   parameter int BLINK_DIV  = 25_000_000,
   parameter int WARN_BLINK = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          system_state,
   input  logic                fault_ack,
   input  logic                lamp_test,
   output logic [NUM_LEDS-1:0] led,
   output logic                blink_phase
);

`ifdef LED_SIM_FAST_BLINK_EN
   localparam int DIV = 8;
`else
   localparam int DIV = BLINK_DIV;
`endif
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [1:0] S_NORMAL  = 2'b01;
   localparam logic [1:0] S_WARNING = 2'b10;
   localparam logic [1:0] S_FAULT   = 2'b11;

   typedef enum logic [1:0] {
      F_IDLE,
      F_ACTIVE,
      F_ACKED
   } fault_t;

   fault_t              st, st_d;
   logic [CW-1:0]       cnt, cnt_d;
   logic                phase_d;
   logic                is_fault;
   logic                entry;
   logic [NUM_LEDS-1:0] led_d;

   assign is_fault = (system_state == S_FAULT);
   assign entry    = is_fault && (st == F_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= F_IDLE;
         cnt         <= '0;
         blink_phase <= 1'b0;
         led         <= '0;
      end else begin
         st          <= st_d;
         cnt         <= cnt_d;
         blink_phase <= phase_d;
         led         <= led_d;
      end
   end

   // Fault entry always wins over a same-cycle acknowledge.
   always_comb begin
      st_d = st;
      if (!is_fault) begin
         st_d = F_IDLE;
      end else begin
         case (st)
            F_IDLE:   st_d = F_ACTIVE;
            F_ACTIVE: if (fault_ack) st_d = F_ACKED;
            F_ACKED:  st_d = F_ACKED;
            default:  st_d = F_IDLE;
         endcase
      end
   end

   // Restart the blink on fault entry so the fault LED lights at once.
   always_comb begin
      cnt_d   = cnt + CW'(1);
      phase_d = blink_phase;
      if (entry) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt_d   = '0;
         phase_d = ~blink_phase;
      end
   end

   // LEDs follow next-state values so they land one cycle after sampling.
   always_comb begin
      led_d    = '0;
      led_d[0] = (system_state == S_NORMAL);
      if (system_state == S_WARNING)
         led_d[1] = (WARN_BLINK != 0) ? phase_d : 1'b1;
      case (st_d)
         F_ACTIVE: led_d[2] = phase_d;
         F_ACKED:  led_d[2] = 1'b1;
         default:  led_d[2] = 1'b0;
      endcase
      if (lamp_test)
         led_d = '1;
   end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl with an 8-cycle blink half-period.
// Instance a: WARN_BLINK=0, instance b: WARN_BLINK=1, shared stimulus.
module tb_led_status_ctrl;

   typedef struct {
      string      nm;
      logic [3:0] exp_a;
      logic [3:0] exp_b;
      logic [3:0] mask_b;
   } entry_t;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] NORM = 2'b01;
   localparam logic [1:0] WARN = 2'b10;
   localparam logic [1:0] FLT  = 2'b11;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] system_state = IDLE;
   logic       fault_ack = 1'b0;
   logic       lamp_test = 1'b0;
   logic [3:0] led_a, led_b;
   logic       ph_a, ph_b;

   entry_t sb[$];
   entry_t e;
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;

   led_status_ctrl #(
      .NUM_LEDS(4), .BLINK_DIV(8), .WARN_BLINK(0)
   ) dut_a (
      .clk(clk), .reset(reset), .system_state(system_state),
      .fault_ack(fault_ack), .lamp_test(lamp_test),
      .led(led_a), .blink_phase(ph_a)
   );

   led_status_ctrl #(
      .NUM_LEDS(4), .BLINK_DIV(8), .WARN_BLINK(1)
   ) dut_b (
      .clk(clk), .reset(reset), .system_state(system_state),
      .fault_ack(fault_ack), .lamp_test(lamp_test),
      .led(led_b), .blink_phase(ph_b)
   );

   // Monitor: one expected entry per clock cycle of output.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (led_a !== e.exp_a) begin
            errors++;
            $display("FAIL %s led_a got=%b exp=%b", e.nm, led_a, e.exp_a);
         end
         if (e.mask_b != 4'b0000) begin
            checks++;
            if ((led_b & e.mask_b) !== (e.exp_b & e.mask_b)) begin
               errors++;
               $display("FAIL %s led_b got=%b exp=%b mask=%b",
                        e.nm, led_b, e.exp_b, e.mask_b);
            end
         end
      end
   end

   task automatic direct(input string nm, input logic [4:0] got,
                         input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", nm, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] s, input logic ack,
                       input logic lamp, input logic [3:0] ea,
                       input logic [3:0] eb, input logic [3:0] mb,
                       input string nm);
      system_state = s;
      fault_ack    = ack;
      lamp_test    = lamp;
      sb.push_back('{nm, ea, eb, mb});
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n, input logic [1:0] s,
                      input logic [3:0] ea, input string nm);
      for (int i = 0; i < n; i++)
         step(s, 1'b0, 1'b0, ea, ea, 4'b1101, nm);
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b1;
      #1;
      direct(nm, {led_a, ph_a}, 5'b0);
      @(posedge clk);
      #2;
      system_state = IDLE;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      do_reset("reset_state");

      // Basic mapping, then fault blink with ack on the entry cycle.
      run(1, NORM, 4'b0001, "normal");
      run(2, WARN, 4'b0010, "warning");
      run(3, IDLE, 4'b0000, "idle");
      step(IDLE, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1101, "ack_in_idle");
      run(3, IDLE, 4'b0000, "idle2");
      step(FLT, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b1101, "fault_entry_ack");
      run(7, FLT, 4'b0100, "blink_on_11");
      run(8, FLT, 4'b0000, "blink_off_19");
      run(8, FLT, 4'b0100, "blink_on_27");
      run(2, FLT, 4'b0000, "blink_off_35");
      step(FLT, 1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1101, "lamp_on");
      step(FLT, 1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1101, "lamp_on2");
      run(4, FLT, 4'b0000, "lamp_rel_off");
      run(2, FLT, 4'b0100, "lamp_rel_on_43");

      // Acknowledge at cycle 13, steady fault LED, then reset mid-ACKED.
      do_reset("reset_active");
      run(10, IDLE, 4'b0000, "idle3");
      run(3, FLT, 4'b0100, "fault2");
      step(FLT, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b1101, "ack_13");
      run(37, FLT, 4'b0100, "acked_steady");
      #2;
      reset = 1'b1;
      #1;
      direct("reset_mid_acked", {led_a, ph_a}, 5'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      run(8, FLT, 4'b0100, "restart_on");
      run(1, FLT, 4'b0000, "restart_off");

      // One-cycle excursions out of FAULT re-arm the blink.
      run(1, NORM, 4'b0001, "excursion_norm");
      run(1, FLT, 4'b0100, "rearm_entry");
      step(FLT, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b1101, "rearm_ack");
      run(1, FLT, 4'b0100, "rearm_acked");
      run(1, WARN, 4'b0010, "excursion_warn");
      run(8, FLT, 4'b0100, "rearm2_on");
      run(1, FLT, 4'b0000, "rearm2_off");

      // Blinking warning LED on instance b.
      do_reset("reset_warn");
      for (int c = 0; c < 24; c++)
         step(WARN, 1'b0, 1'b0, 4'b0010,
              (((c + 1) / 8) % 2 == 1) ? 4'b0010 : 4'b0000,
              4'b1111, "warn_blink");

      system_state = IDLE;
      @(posedge clk);
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 3, number of LED outputs (legal range 3..16).
REQ-002 SHALL have parameter BLINK_DIV, default 25_000_000, clk cycles per blink half-period (≥2).
REQ-003 SHALL have parameter WARN_BLINK, default 0; 0 = warning LED steady, 1 = warning LED blinks.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port system_state  input  2  00 IDLE, 01 NORMAL, 10 WARNING, 11 FAULT.
REQ-007 SHALL have port fault_ack  input  1  operator fault acknowledge, single-cycle pulse or level.
REQ-008 SHALL have port lamp_test  input  1  level; forces all LEDs on.
REQ-009 SHALL have port led  output  NUM_LEDS  registered LED drive; bit0 normal, bit1 warning, bit2 fault, bits 3+ spare.
REQ-010 SHALL have port blink_phase  output  1  registered current blink phase.

Function
REQ-011 SHALL run a prescaler counting 0..DIV-1, wrapping to 0 and toggling blink_phase on the wrap cycle (DIV = effective divider, see REQ-026).
REQ-012 SHALL hold a fault FSM with states F_IDLE, F_ACTIVE, F_ACKED.
REQ-013 SHALL transition F_IDLE->F_ACTIVE when system_state becomes FAULT; F_ACTIVE->F_ACKED on fault_ack=1 while system_state=FAULT; any state->F_IDLE when system_state≠FAULT.
REQ-014 SHALL ignore fault_ack in the cycle FAULT is first sampled (entry wins); fault_ack in F_IDLE or F_ACKED has no effect.
REQ-015 SHALL, on the F_IDLE->F_ACTIVE transition, clear the prescaler to 0 and set blink_phase to 1 in the same edge, so the fault LED lights with no delay.
REQ-016 SHALL update led one clk after system_state is sampled (1-cycle latency); no combinational path from inputs to led.
REQ-017 SHALL drive led[0]=1 only in NORMAL.
REQ-018 SHALL drive led[1] in WARNING: 1 when WARN_BLINK=0, blink_phase when WARN_BLINK=1; 0 otherwise.
REQ-019 SHALL drive led[2]=blink_phase in F_ACTIVE, 1 in F_ACKED, 0 in F_IDLE.
REQ-020 SHALL drive led[NUM_LEDS-1:3]=0 except during lamp test.
REQ-021 SHALL drive all led bits to 1 one cycle after lamp_test=1; FSM and prescaler keep running, and normal mapping resumes one cycle after lamp_test=0.
REQ-022 SHALL drive all LEDs off in IDLE.
REQ-023 SHALL leave FAULT->FAULT re-entry unaffected by a one-cycle excursion only if FAULT is continuously sampled; any non-FAULT sample re-arms F_ACTIVE on next entry.

Reset
REQ-024 SHALL, while reset=1, force led=0, blink_phase=0, prescaler=0, FSM=F_IDLE, asynchronously.
REQ-025 SHALL resume normal operation on the first clk edge after reset deasserts; reset mid-fault discards any acknowledge.

Configuration
REQ-026 SHALL, when macro LED_SIM_FAST_BLINK_EN is defined, use DIV=8 regardless of BLINK_DIV; when undefined, DIV=BLINK_DIV.

Verification (LED_SIM_FAST_BLINK_EN defined, NUM_LEDS=4, WARN_BLINK=0)
REQ-027 SHALL check: reset released, state NORMAL at cycle 0 -> led=4'b0001 at cycle 1; state WARNING -> led=4'b0010 next cycle.
REQ-028 SHALL check: state FAULT at cycle 10 -> led[2]=1 at cycle 11, 0 at cycle 19, 1 at cycle 27 (8-cycle half-period).
REQ-029 SHALL check: FAULT with fault_ack pulse at cycle 13 -> led[2]=1 steady from cycle 14 for ≥32 cycles; fault_ack on entry cycle ignored (still blinks).
REQ-030 SHALL check: lamp_test=1 during FAULT blink -> led=4'b1111 next cycle; release -> led[2] equals blink_phase continuing unbroken phase.
REQ-031 SHALL check: reset asserted mid-F_ACKED -> led=0 immediately; after release with FAULT held -> F_ACTIVE blinking restarts with led[2]=1 first.
REQ-032 SHALL check: rebuild with WARN_BLINK=1, state WARNING -> led[1] toggles every 8 cycles.
